uart_rx_32: RTL and testbench
=============================

Name: uart_rx_32

Overview:
- Receive-side companion of the 32-bit UART transmitter; sits downstream of the serial line that the transmitter drives.
- Deserialises four consecutive 8N1 frames (LSB first) and assembles them into one 32-bit word.
- Byte order matches the transmitter: first frame received → bits [7:0], fourth frame → bits [31:24].
- Flags framing errors and inter-byte timeouts so a lost byte never shifts word alignment permanently.

Parameters:
- CLOCK_FREQUENCY, 25_000_000, system clock in Hz.
- BAUD_RATE, 9600, line rate in bit/s.
- TIMEOUT_BITS, 20, idle bit-times allowed between frames of one word before the partial word is discarded.
- Derived: BIT_PERIOD = CLOCK_FREQUENCY/BAUD_RATE clocks (2604 at defaults); HALF_PERIOD = BIT_PERIOD/2.

Ports:
- clockIN  in  1  system clock.
- rxResetIN  in  1  asynchronous, active-high reset.
- rxIN  in  1  serial line; asynchronous to clockIN; idle high.
- rxDataOUT  out  32  last completed word; holds until the next word completes.
- rxValidOUT  out  1  one-clock pulse when rxDataOUT updates.
- rxBusyOUT  out  1  high while a frame is in progress (state ≠ IDLE).
- rxByteCntOUT  out  2  number of bytes of the current word already received.
- rxFrameErrOUT  out  1  one-clock pulse on a bad stop bit.
- rxTimeoutOUT  out  1  one-clock pulse when a partial word is discarded on timeout.

Behaviour:
- Reset (async assert, sync release): rxDataOUT=0, rxValidOUT=0, rxBusyOUT=0, rxByteCntOUT=0, both error pulses 0, state=IDLE. Synchroniser flops reset to 1.
- Input path: rxIN passes through a 2-flop synchroniser, then a third flop for edge detection. A start edge is synchronised value 0 with previous value 1.
- FSM states: IDLE, START, DATA, STOP, BREAK.
- IDLE:
  - On a start edge → START, bit counter loaded with HALF_PERIOD-1.
  - Otherwise, if byte count ≠ 0, the gap counter increments. When it reaches TIMEOUT_BITS*BIT_PERIOD-1: pulse rxTimeoutOUT, clear byte count and gap counter.
  - The gap counter clears on every start edge.
- START: at counter expiry (mid start bit), sample the line.
  - Sample 0 → DATA, bit index 0, counter BIT_PERIOD-1.
  - Sample 1 → false start: return to IDLE with no error.
- DATA: at each counter expiry, shift the sampled bit into the MSB of an 8-bit shifter (LSB-first assembly) and reload the counter. After the 8th sample → STOP.
- STOP: at expiry (mid stop bit), sample the line.
  - Sample 1: write the byte into word lane rxByteCntOUT and increment the count. If the count was 3: the next clock updates rxDataOUT with the full word, rxValidOUT=1 for one clock, count wraps to 0. State → IDLE at the mid-stop point, so a back-to-back start bit (zero inter-frame gap) is caught.
  - Sample 0: pulse rxFrameErrOUT, discard the partial word (count=0, rxDataOUT unchanged), → BREAK.
- BREAK: wait until the synchronised line is 1, then → IDLE. The next start edge is detected only after a 1→0 transition.
- Latency: rxValidOUT rises 1 clock after the 4th stop-bit sample. From the rxIN falling edge of the 4th start bit that is 2 (sync) + 1 (edge) + HALF_PERIOD + 9*BIT_PERIOD + 1 clocks.
- rxValidOUT, rxFrameErrOUT and rxTimeoutOUT are mutually exclusive in any cycle.
- Reset asserted mid-frame or mid-word: all state is lost and no pulse is produced. After release the block waits for a fresh start edge; if the line is low at release, nothing is detected until a 1→0 transition.
- Counters are sized with $clog2 of their maximum value. All arithmetic is unsigned with no wrap inside a frame.

Test Plan:
- Setup for all scenarios: CLOCK_FREQUENCY=160, BAUD_RATE=10 (BIT_PERIOD=16), TIMEOUT_BITS=4.
- Send 0xA5,0x5A,0xC3,0x3C back-to-back with 1 stop bit → one rxValidOUT pulse, rxDataOUT=0x3CC35AA5, no error pulses.
- Two words back-to-back (0x12345678, then 0xDEADBEEF) with zero gap → two valid pulses exactly 40*16 clocks apart, correct data each time.
- 2nd byte sent with stop bit=0, then a full 4-byte word 0x01020304 → rxFrameErrOUT pulse, rxByteCntOUT=0; the next valid word is 0x01020304.
- Glitch: rxIN low for 5 clocks → no state change, rxBusyOUT returns 0, no error. Then send a valid word 0x0000FFFF → received correctly.
- Send 2 bytes, then idle ≥ 4*16 clocks → rxTimeoutOUT pulse, count=0. Then a 4-byte word 0xCAFEF00D → rxDataOUT=0xCAFEF00D.
- Assert rxResetIN during the 3rd byte of a word → outputs return to reset values immediately. The next full word is received correctly with no stale bytes.

Source files
------------

// File: rtl/uart_rx_32.sv
// rtl/uart_rx_32.sv - 8N1 receiver assembling four frames (first frame in bits [7:0]) into a 32-bit word
module uart_rx_32 #(
  parameter int CLOCK_FREQUENCY = 25_000_000,
  parameter int BAUD_RATE       = 9600,
  parameter int TIMEOUT_BITS    = 20
) (
  input  logic        clockIN,
  input  logic        rxResetIN,
  input  logic        rxIN,
  output logic [31:0] rxDataOUT,
  output logic        rxValidOUT,
  output logic        rxBusyOUT,
  output logic [1:0]  rxByteCntOUT,
  output logic        rxFrameErrOUT,
  output logic        rxTimeoutOUT
);

  localparam int BIT_PERIOD  = CLOCK_FREQUENCY / BAUD_RATE;
  localparam int HALF_PERIOD = BIT_PERIOD / 2;
  localparam int TIMEOUT_CYC = TIMEOUT_BITS * BIT_PERIOD;
  localparam int CNT_W       = (BIT_PERIOD > 2) ? $clog2(BIT_PERIOD) : 1;
  localparam int GAP_W       = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  localparam logic [CNT_W-1:0] BIT_RELOAD  = CNT_W'(BIT_PERIOD - 1);
  localparam logic [CNT_W-1:0] HALF_RELOAD = CNT_W'(HALF_PERIOD - 1);
  localparam logic [GAP_W-1:0] GAP_LAST    = GAP_W'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

  state_t             state_q, state_d;
  logic               sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
  logic [1:0]         warm_q, warm_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2:0]         bit_idx_q, bit_idx_d;
  logic [7:0]         shift_q, shift_d;
  logic [31:0]        word_q, word_d, data_q, data_d;
  logic [1:0]         byte_cnt_q, byte_cnt_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic               done_q, done_d, valid_q, valid_d;
  logic               ferr_q, ferr_d, tmo_q, tmo_d;
  logic               start_edge;

  // Edge detection stays disarmed until the edge flop holds a real line value,
  // so a line held low through reset release is not mistaken for a start bit.
  assign start_edge = (warm_q == 2'd3) && prev_q && !sync2_q;

  always_comb begin
    state_d    = state_q;
    sync1_d    = rxIN;
    sync2_d    = sync1_q;
    prev_d     = sync2_q;
    warm_d     = (warm_q == 2'd3) ? warm_q : warm_q + 2'd1;
    cnt_d      = cnt_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    word_d     = word_q;
    byte_cnt_d = byte_cnt_q;
    gap_d      = gap_q;
    done_d     = 1'b0;
    valid_d    = done_q;
    data_d     = done_q ? word_q : data_q;
    ferr_d     = 1'b0;
    tmo_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_edge) begin
          state_d = START;
          cnt_d   = HALF_RELOAD;
          gap_d   = '0;
        end else if (byte_cnt_q != 2'd0) begin
          if (gap_q == GAP_LAST) begin
            tmo_d      = 1'b1;
            byte_cnt_d = 2'd0;
            gap_d      = '0;
          end else begin
            gap_d = gap_q + GAP_W'(1);
          end
        end
      end
      START: begin
        if (cnt_q == '0) begin
          if (!sync2_q) begin
            state_d   = DATA;
            bit_idx_d = 3'd0;
            cnt_d     = BIT_RELOAD;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DATA: begin
        if (cnt_q == '0) begin
          shift_d   = {sync2_q, shift_q[7:1]};
          cnt_d     = BIT_RELOAD;
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = STOP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      STOP: begin
        if (cnt_q == '0) begin
          if (sync2_q) begin
            word_d[{byte_cnt_q, 3'b000} +: 8] = shift_q;
            byte_cnt_d = byte_cnt_q + 2'd1;
            done_d     = (byte_cnt_q == 2'd3);
            state_d    = IDLE;
          end else begin
            ferr_d     = 1'b1;
            byte_cnt_d = 2'd0;
            state_d    = BREAK;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      BREAK: begin
        if (sync2_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clockIN or posedge rxResetIN) begin
    if (rxResetIN) begin
      state_q    <= IDLE;
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      prev_q     <= 1'b1;
      warm_q     <= 2'd0;
      cnt_q      <= '0;
      bit_idx_q  <= 3'd0;
      shift_q    <= 8'd0;
      word_q     <= 32'd0;
      data_q     <= 32'd0;
      byte_cnt_q <= 2'd0;
      gap_q      <= '0;
      done_q     <= 1'b0;
      valid_q    <= 1'b0;
      ferr_q     <= 1'b0;
      tmo_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      prev_q     <= prev_d;
      warm_q     <= warm_d;
      cnt_q      <= cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      word_q     <= word_d;
      data_q     <= data_d;
      byte_cnt_q <= byte_cnt_d;
      gap_q      <= gap_d;
      done_q     <= done_d;
      valid_q    <= valid_d;
      ferr_q     <= ferr_d;
      tmo_q      <= tmo_d;
    end
  end

  assign rxDataOUT     = data_q;
  assign rxValidOUT    = valid_q;
  assign rxBusyOUT     = (state_q != IDLE);
  assign rxByteCntOUT  = byte_cnt_q;
  assign rxFrameErrOUT = ferr_q;
  assign rxTimeoutOUT  = tmo_q;

endmodule

// File: tb/tb_uart_rx_32.sv
// tb/tb_uart_rx_32.sv - bench for uart_rx_32: directed word table, corner sequences, random frames vs. a byte-stream model
module tb_uart_rx_32;
  localparam int BP      = 16;
  localparam int LATENCY = 2 + 1 + BP / 2 + 9 * BP + 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx  = 1'b1;
  logic [31:0] rx_data;
  logic        rx_valid, rx_busy, rx_ferr, rx_tmo;
  logic [1:0]  rx_cnt;

  uart_rx_32 #(.CLOCK_FREQUENCY(160), .BAUD_RATE(10), .TIMEOUT_BITS(4)) dut (
    .clockIN(clk), .rxResetIN(rst), .rxIN(rx),
    .rxDataOUT(rx_data), .rxValidOUT(rx_valid), .rxBusyOUT(rx_busy),
    .rxByteCntOUT(rx_cnt), .rxFrameErrOUT(rx_ferr), .rxTimeoutOUT(rx_tmo)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] vq[$];
  int          vt[$];
  int          fe_cnt = 0, to_cnt = 0, excl_bad = 0, busy_cnt = 0;
  always @(negedge clk) begin
    if (rx_valid) begin
      vq.push_back(rx_data);
      vt.push_back(cyc);
    end
    if (rx_ferr) fe_cnt++;
    if (rx_tmo) to_cnt++;
    if (rx_busy) busy_cnt++;
    if (int'(rx_valid) + int'(rx_ferr) + int'(rx_tmo) > 1) excl_bad++;
  end

  int n_cmp = 0, n_bad = 0;
  int last_fall = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    repeat (BP) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    last_fall = cyc;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop);
  endtask

  task automatic idle_bits(input int n);
    for (int i = 0; i < n; i++) send_bit(1'b1);
  endtask

  task automatic send_word4(input logic [7:0] b0, b1, b2, b3);
    send_byte(b0, 1'b1);
    send_byte(b1, 1'b1);
    send_byte(b2, 1'b1);
    send_byte(b3, 1'b1);
  endtask

  task automatic expect_one_word(input string name, input int base, input logic [31:0] exp);
    check({name, "_count"}, 32'(vq.size() - base), 32'd1);
    if (vq.size() > base) check({name, "_data"}, vq[base], exp);
  endtask

  typedef struct {
    logic [7:0]  b0, b1, b2, b3;
    logic [31:0] exp;
  } vec_t;

  initial begin
    vec_t vecs[6];
    int   fall4[6];
    int   base, fe0, to0, bz0;
    logic [7:0]  rb[48];
    logic        rbad[48];
    int          rgap[48];
    logic [31:0] exp_words[$];
    logic [31:0] acc;
    int          mcnt, exp_fe, exp_to;

    vecs[0] = '{8'hA5, 8'h5A, 8'hC3, 8'h3C, 32'h3CC35AA5};
    vecs[1] = '{8'h78, 8'h56, 8'h34, 8'h12, 32'h12345678};
    vecs[2] = '{8'hEF, 8'hBE, 8'hAD, 8'hDE, 32'hDEADBEEF};
    vecs[3] = '{8'hFF, 8'hFF, 8'h00, 8'h00, 32'h0000FFFF};
    vecs[4] = '{8'h0D, 8'hF0, 8'hFE, 8'hCA, 32'hCAFEF00D};
    vecs[5] = '{8'h04, 8'h03, 8'h02, 8'h01, 32'h01020304};

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_data", rx_data, 32'd0);
    check("rst_valid", 32'(rx_valid), 32'd0);
    check("rst_busy", 32'(rx_busy), 32'd0);
    check("rst_cnt", 32'(rx_cnt), 32'd0);
    check("rst_ferr", 32'(rx_ferr), 32'd0);
    check("rst_tmo", 32'(rx_tmo), 32'd0);
    rst = 1'b0;
    idle_bits(2);

    // Table: six words back-to-back, zero inter-frame gap
    base = vq.size(); fe0 = fe_cnt; to0 = to_cnt;
    for (int i = 0; i < 6; i++) begin
      send_word4(vecs[i].b0, vecs[i].b1, vecs[i].b2, vecs[i].b3);
      fall4[i] = last_fall;
    end
    idle_bits(2);
    check("tbl_count", 32'(vq.size() - base), 32'd6);
    for (int i = 0; i < 6; i++) begin
      if (vq.size() > base + i) begin
        check($sformatf("tbl_data%0d", i), vq[base + i], vecs[i].exp);
        check($sformatf("tbl_lat%0d", i), 32'(vt[base + i] - fall4[i]), 32'(LATENCY));
        if (i > 0)
          check($sformatf("tbl_gap%0d", i), 32'(vt[base + i] - vt[base + i - 1]), 32'(40 * BP));
      end
    end
    check("tbl_ferr", 32'(fe_cnt - fe0), 32'd0);
    check("tbl_tmo", 32'(to_cnt - to0), 32'd0);

    // Bad stop bit on the 2nd byte, then a clean word
    fe0 = fe_cnt;
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b0);
    idle_bits(1);
    check("fe_pulse", 32'(fe_cnt - fe0), 32'd1);
    check("fe_cnt0", 32'(rx_cnt), 32'd0);
    base = vq.size();
    send_word4(8'h04, 8'h03, 8'h02, 8'h01);
    idle_bits(1);
    expect_one_word("fe_next", base, 32'h01020304);

    // Short glitch
    fe0 = fe_cnt; base = vq.size();
    rx = 1'b0;
    repeat (5) @(posedge clk);
    #1 rx = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    check("gl_busy", 32'(rx_busy), 32'd0);
    check("gl_ferr", 32'(fe_cnt - fe0), 32'd0);
    check("gl_cnt", 32'(rx_cnt), 32'd0);
    check("gl_novalid", 32'(vq.size() - base), 32'd0);
    send_word4(8'hFF, 8'hFF, 8'h00, 8'h00);
    idle_bits(1);
    expect_one_word("gl_next", base, 32'h0000FFFF);

    // Inter-byte timeout
    to0 = to_cnt;
    send_byte(8'h55, 1'b1);
    send_byte(8'h66, 1'b1);
    check("to_cnt2", 32'(rx_cnt), 32'd2);
    idle_bits(6);
    check("to_pulse", 32'(to_cnt - to0), 32'd1);
    check("to_cnt0", 32'(rx_cnt), 32'd0);
    base = vq.size();
    send_word4(8'h0D, 8'hF0, 8'hFE, 8'hCA);
    idle_bits(1);
    expect_one_word("to_next", base, 32'hCAFEF00D);

    // Reset during the 3rd byte, released with the line low
    send_byte(8'h99, 1'b1);
    send_byte(8'h88, 1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    rst = 1'b1;
    #1;
    check("mr_data", rx_data, 32'd0);
    check("mr_busy", 32'(rx_busy), 32'd0);
    check("mr_cnt", 32'(rx_cnt), 32'd0);
    check("mr_valid", 32'(rx_valid), 32'd0);
    rx = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    fe0 = fe_cnt; bz0 = busy_cnt; base = vq.size();
    repeat (3 * BP) @(posedge clk);
    #1;
    check("mr_low_busy", 32'(busy_cnt - bz0), 32'd0);
    check("mr_low_ferr", 32'(fe_cnt - fe0), 32'd0);
    rx = 1'b1;
    idle_bits(2);
    send_word4(8'hEF, 8'hCD, 8'hAB, 8'h89);
    idle_bits(1);
    expect_one_word("mr_next", base, 32'h89ABCDEF);

    // Random frames against a byte-stream model
    for (int i = 0; i < 48; i++) begin
      rb[i]   = 8'($urandom_range(0, 255));
      rbad[i] = ($urandom_range(0, 7) == 0);
      case ($urandom_range(0, 4))
        0: rgap[i] = 0;
        1: rgap[i] = 1;
        2: rgap[i] = 2;
        3: rgap[i] = 5;
        default: rgap[i] = 6;
      endcase
      if (i > 0 && rbad[i - 1] && rgap[i] == 0) rgap[i] = 1;
    end
    mcnt = 0; acc = 32'd0; exp_fe = 0; exp_to = 0;
    for (int i = 0; i < 48; i++) begin
      if (i > 0 && rgap[i] >= 4 && mcnt != 0) begin
        exp_to++;
        mcnt = 0;
      end
      if (rbad[i]) begin
        exp_fe++;
        mcnt = 0;
      end else begin
        acc[mcnt * 8 +: 8] = rb[i];
        mcnt++;
        if (mcnt == 4) begin
          exp_words.push_back(acc);
          mcnt = 0;
        end
      end
    end
    if (mcnt != 0) exp_to++;

    base = vq.size(); fe0 = fe_cnt; to0 = to_cnt;
    for (int i = 0; i < 48; i++) begin
      if (i > 0) idle_bits(rgap[i]);
      send_byte(rb[i], !rbad[i]);
    end
    idle_bits(6);
    check("rnd_words", 32'(vq.size() - base), 32'(exp_words.size()));
    for (int i = 0; i < exp_words.size(); i++)
      if (vq.size() > base + i) check($sformatf("rnd_data%0d", i), vq[base + i], exp_words[i]);
    check("rnd_ferr", 32'(fe_cnt - fe0), 32'(exp_fe));
    check("rnd_tmo", 32'(to_cnt - to0), 32'(exp_to));
    check("pulse_excl", 32'(excl_bad), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
